// File: rtl/ad9866_gain_sched.sv
// Gain-update scheduler for the AD9866 SPI programmer: waits out the init burst,
// coalesces RX/TX gain writes and issues one programmer request at a time.
module ad9866_gain_sched #(
  parameter int INIT_HOLDOFF = 4096,
  parameter int ACK_TIMEOUT  = 64,
  parameter int GAP_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_gain_wr,
  input  logic [5:0] rx_gain_in,
  input  logic       tx_gain_wr,
  input  logic [5:0] tx_gain_in,
  input  logic       ptt,
  input  logic       sen_n,
  output logic       ext_rx_rqst,
  output logic [5:0] rx_gain,
  output logic       ext_tx_rqst,
  output logic [5:0] tx_gain,
  output logic       rx_pending,
  output logic       tx_pending,
  output logic       busy,
  output logic       done,
  output logic       timeout
);

  localparam int CNT_M1  = (INIT_HOLDOFF > ACK_TIMEOUT) ? INIT_HOLDOFF : ACK_TIMEOUT;
  localparam int CNT_MAX = (CNT_M1 > GAP_CYCLES) ? CNT_M1 : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] HOLD_LAST = CW'(INIT_HOLDOFF - 1);
  localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    ST_HOLDOFF = 3'd0,
    ST_IDLE    = 3'd1,
    ST_REQ     = 3'd2,
    ST_XFER    = 3'd3,
    ST_GAP     = 3'd4
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [5:0]    rx_val_r, rx_val_s, tx_val_r, tx_val_s;
  logic [5:0]    rx_gain_r, rx_gain_s, tx_gain_r, tx_gain_s;
  logic          rx_pend_r, rx_pend_s, tx_pend_r, tx_pend_s;
  logic          side_tx_r, side_tx_s;
  logic          rx_rqst_r, rx_rqst_s, tx_rqst_r, tx_rqst_s;
  logic          busy_r, busy_s, done_r, done_s, timeout_r, timeout_s;

  // State register and all registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_HOLDOFF;
      cnt_r     <= '0;
      rx_val_r  <= 6'd0;
      tx_val_r  <= 6'd0;
      rx_gain_r <= 6'd0;
      tx_gain_r <= 6'd0;
      rx_pend_r <= 1'b0;
      tx_pend_r <= 1'b0;
      side_tx_r <= 1'b0;
      rx_rqst_r <= 1'b0;
      tx_rqst_r <= 1'b0;
      busy_r    <= 1'b1;
      done_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      rx_val_r  <= rx_val_s;
      tx_val_r  <= tx_val_s;
      rx_gain_r <= rx_gain_s;
      tx_gain_r <= tx_gain_s;
      rx_pend_r <= rx_pend_s;
      tx_pend_r <= tx_pend_s;
      side_tx_r <= side_tx_s;
      rx_rqst_r <= rx_rqst_s;
      tx_rqst_r <= tx_rqst_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      timeout_r <= timeout_s;
    end
  end

  // Next-state, capture and arbitration logic
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    rx_val_s  = rx_gain_wr ? rx_gain_in : rx_val_r;
    tx_val_s  = tx_gain_wr ? tx_gain_in : tx_val_r;
    rx_gain_s = rx_gain_r;
    tx_gain_s = tx_gain_r;
    rx_pend_s = rx_pend_r;
    tx_pend_s = tx_pend_r;
    side_tx_s = side_tx_r;
    rx_rqst_s = rx_rqst_r;
    tx_rqst_s = tx_rqst_r;
    done_s    = 1'b0;
    timeout_s = 1'b0;

    case (state_r)
      ST_HOLDOFF: begin
        // Leave only once the programmer's init burst is idle
        if (cnt_r == HOLD_LAST) begin
          if (sen_n) begin
            state_s = ST_IDLE;
            cnt_s   = '0;
          end else begin
            cnt_s = cnt_r;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_IDLE: begin
        if (tx_pend_r && (ptt || !rx_pend_r)) begin
          tx_gain_s = tx_val_r;
          tx_pend_s = 1'b0;
          side_tx_s = 1'b1;
          tx_rqst_s = 1'b1;
          rx_rqst_s = 1'b0;
          cnt_s     = '0;
          state_s   = ST_REQ;
        end else if (rx_pend_r) begin
          rx_gain_s = rx_val_r;
          rx_pend_s = 1'b0;
          side_tx_s = 1'b0;
          rx_rqst_s = 1'b1;
          tx_rqst_s = 1'b0;
          cnt_s     = '0;
          state_s   = ST_REQ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (!sen_n) begin
          rx_rqst_s = 1'b0;
          tx_rqst_s = 1'b0;
          cnt_s     = '0;
          state_s   = ST_XFER;
        end else if (cnt_r == ACK_LAST) begin
          // Abort and requeue the side so it retries after the gap
          rx_rqst_s = 1'b0;
          tx_rqst_s = 1'b0;
          timeout_s = 1'b1;
          cnt_s     = '0;
          state_s   = ST_GAP;
          if (side_tx_r) begin
            tx_pend_s = 1'b1;
          end else begin
            rx_pend_s = 1'b1;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_XFER: begin
        if (sen_n) begin
          done_s  = 1'b1;
          cnt_s   = '0;
          state_s = ST_GAP;
        end else begin
          state_s = ST_XFER;
        end
      end
      ST_GAP: begin
        if (cnt_r == GAP_LAST) begin
          cnt_s   = '0;
          state_s = ST_IDLE;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s   = ST_HOLDOFF;
        cnt_s     = '0;
        rx_rqst_s = 1'b0;
        tx_rqst_s = 1'b0;
      end
    endcase

    // A strobe always wins over the issue-time clear
    rx_pend_s = rx_pend_s | rx_gain_wr;
    tx_pend_s = tx_pend_s | tx_gain_wr;
    busy_s    = (state_s != ST_IDLE) || rx_pend_s || tx_pend_s;
  end

  assign ext_rx_rqst = rx_rqst_r;
  assign ext_tx_rqst = tx_rqst_r;
  assign rx_gain     = rx_gain_r;
  assign tx_gain     = tx_gain_r;
  assign rx_pending  = rx_pend_r;
  assign tx_pending  = tx_pend_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign timeout     = timeout_r;

endmodule

// File: tb/tb_ad9866_gain_sched.sv
// Directed bench for ad9866_gain_sched with short holdoff/timeout and a
// bench-driven stand-in for the SPI programmer's sen_n handshake.
module tb_ad9866_gain_sched;

  localparam int HOLD = 64;
  localparam int ACK  = 8;
  localparam int GAP  = 4;

  logic       clk, reset_n;
  logic       rx_gain_wr, tx_gain_wr, ptt, sen_n;
  logic [5:0] rx_gain_in, tx_gain_in;
  logic       ext_rx_rqst, ext_tx_rqst;
  logic [5:0] rx_gain, tx_gain;
  logic       rx_pending, tx_pending, busy, done, timeout;

  int total = 0;
  int bad = 0;
  int cyc;
  int both_hi = 0;
  int last_req_cyc = 0;
  int done_cyc = 0;

  ad9866_gain_sched #(.INIT_HOLDOFF(HOLD), .ACK_TIMEOUT(ACK), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset_n(reset_n),
    .rx_gain_wr(rx_gain_wr), .rx_gain_in(rx_gain_in),
    .tx_gain_wr(tx_gain_wr), .tx_gain_in(tx_gain_in),
    .ptt(ptt), .sen_n(sen_n),
    .ext_rx_rqst(ext_rx_rqst), .rx_gain(rx_gain),
    .ext_tx_rqst(ext_tx_rqst), .tx_gain(tx_gain),
    .rx_pending(rx_pending), .tx_pending(tx_pending),
    .busy(busy), .done(done), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (ext_rx_rqst && ext_tx_rqst) both_hi = both_hi + 1;
  end

  task automatic idle_wait(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic start_xfer(input bit tx, input logic [5:0] exp, input string nm);
    int w;
    w = 0;
    while (w < 200 && !(tx ? ext_tx_rqst : ext_rx_rqst)) begin
      @(negedge clk);
      w++;
    end
    last_req_cyc = cyc;
    total++;
    if (w >= 200) begin bad++; $display("FAIL %s req_wait: got no request, want request", nm); end
    total++;
    if ((tx ? tx_gain : rx_gain) !== exp) begin
      bad++; $display("FAIL %s gain: got %h want %h", nm, tx ? tx_gain : rx_gain, exp);
    end
    total++;
    if ((tx ? ext_rx_rqst : ext_tx_rqst) !== 1'b0) begin
      bad++; $display("FAIL %s other_rqst: got 1 want 0", nm);
    end
    @(negedge clk);
    sen_n = 1'b0;
    @(negedge clk);
    total++;
    if ((ext_rx_rqst | ext_tx_rqst) !== 1'b0) begin
      bad++; $display("FAIL %s rqst_drop: got %b%b want 00", nm, ext_rx_rqst, ext_tx_rqst);
    end
  endtask

  task automatic end_xfer(input bit tx, input logic [5:0] exp, input string nm);
    idle_wait(2);
    sen_n = 1'b1;
    @(negedge clk);
    done_cyc = cyc;
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL %s done: got %b want 1", nm, done); end
    total++;
    if ((tx ? tx_gain : rx_gain) !== exp) begin
      bad++; $display("FAIL %s gain_hold: got %h want %h", nm, tx ? tx_gain : rx_gain, exp);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL %s done_pulse: got %b want 0", nm, done); end
  endtask

  task automatic test_reset;
    idle_wait(2);
    total++;
    if ({ext_rx_rqst, ext_tx_rqst, rx_gain, tx_gain, rx_pending, tx_pending, done, timeout} !== 18'd0) begin
      bad++; $display("FAIL reset_outputs: got %h want 0",
        {ext_rx_rqst, ext_tx_rqst, rx_gain, tx_gain, rx_pending, tx_pending, done, timeout});
    end
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy: got %b want 1", busy); end
    reset_n = 1'b1;
  endtask

  task automatic test_holdoff;
    while (cyc < 10) @(negedge clk);
    rx_gain_wr = 1'b1; rx_gain_in = 6'h2A;
    @(negedge clk);
    rx_gain_wr = 1'b0;
    total++;
    if ({rx_pending, ext_rx_rqst, busy} !== 3'b101) begin
      bad++; $display("FAIL holdoff_capture: got %b want 101", {rx_pending, ext_rx_rqst, busy});
    end
    start_xfer(1'b0, 6'h2A, "holdoff");
    total++;
    if (last_req_cyc < HOLD) begin
      bad++; $display("FAIL holdoff_early: got request at %0d want >= %0d", last_req_cyc, HOLD);
    end
    end_xfer(1'b0, 6'h2A, "holdoff");
  endtask

  task automatic test_priority;
    idle_wait(8);
    ptt = 1'b1;
    rx_gain_wr = 1'b1; rx_gain_in = 6'h11;
    tx_gain_wr = 1'b1; tx_gain_in = 6'h05;
    @(negedge clk);
    rx_gain_wr = 1'b0; tx_gain_wr = 1'b0;
    start_xfer(1'b1, 6'h05, "prio_tx");
    total++;
    if ({rx_pending, tx_pending} !== 2'b10) begin
      bad++; $display("FAIL prio_pending: got %b want 10", {rx_pending, tx_pending});
    end
    end_xfer(1'b1, 6'h05, "prio_tx");
    start_xfer(1'b0, 6'h11, "prio_rx");
    total++;
    if (last_req_cyc - done_cyc < GAP + 1) begin
      bad++; $display("FAIL prio_gap: got %0d cycles want >= %0d", last_req_cyc - done_cyc, GAP + 1);
    end
    end_xfer(1'b0, 6'h11, "prio_rx");
    ptt = 1'b0;
  endtask

  task automatic test_coalesce;
    int seen;
    idle_wait(8);
    rx_gain_wr = 1'b1; rx_gain_in = 6'h3C;
    @(negedge clk);
    rx_gain_wr = 1'b0;
    start_xfer(1'b0, 6'h3C, "coal_first");
    for (int i = 1; i <= 3; i++) begin
      rx_gain_wr = 1'b1; rx_gain_in = 6'(i);
      @(negedge clk);
    end
    rx_gain_wr = 1'b0;
    total++;
    if ({rx_pending, rx_gain} !== {1'b1, 6'h3C}) begin
      bad++; $display("FAIL coal_xfer: got %b/%h want 1/3c", rx_pending, rx_gain);
    end
    end_xfer(1'b0, 6'h3C, "coal_first");
    start_xfer(1'b0, 6'h03, "coal_second");
    end_xfer(1'b0, 6'h03, "coal_second");
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ext_rx_rqst || ext_tx_rqst) seen++;
    end
    total++;
    if (seen !== 0 || rx_pending !== 1'b0) begin
      bad++; $display("FAIL coal_extra: got %0d request cycles pending=%b want 0/0", seen, rx_pending);
    end
  endtask

  task automatic test_timeout;
    int hi;
    int to_cyc;
    idle_wait(8);
    rx_gain_wr = 1'b1; rx_gain_in = 6'h15;
    @(negedge clk);
    rx_gain_wr = 1'b0;
    hi = 0;
    while (!ext_rx_rqst && hi < 20) begin @(negedge clk); hi++; end
    hi = 0;
    while (ext_rx_rqst && hi < 30) begin hi++; @(negedge clk); end
    to_cyc = cyc;
    total++;
    if (hi !== ACK) begin bad++; $display("FAIL to_length: got %0d want %0d", hi, ACK); end
    total++;
    if ({timeout, rx_pending} !== 2'b11) begin
      bad++; $display("FAIL to_pulse: got %b want 11", {timeout, rx_pending});
    end
    @(negedge clk);
    total++;
    if (timeout !== 1'b0) begin bad++; $display("FAIL to_width: got %b want 0", timeout); end
    start_xfer(1'b0, 6'h15, "to_retry");
    total++;
    if (last_req_cyc - to_cyc < GAP + 1) begin
      bad++; $display("FAIL to_gap: got %0d cycles want >= %0d", last_req_cyc - to_cyc, GAP + 1);
    end
    end_xfer(1'b0, 6'h15, "to_retry");
  endtask

  task automatic test_async_reset;
    int w;
    idle_wait(8);
    ptt = 1'b1;
    rx_gain_wr = 1'b1; rx_gain_in = 6'h33;
    tx_gain_wr = 1'b1; tx_gain_in = 6'h22;
    @(negedge clk);
    rx_gain_wr = 1'b0; tx_gain_wr = 1'b0;
    start_xfer(1'b1, 6'h22, "areset");
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({rx_pending, tx_pending, ext_rx_rqst, ext_tx_rqst, busy, tx_gain} !== {5'b00001, 6'h00}) begin
      bad++; $display("FAIL areset_xfer: got %b/%h want 00001/00",
        {rx_pending, tx_pending, ext_rx_rqst, ext_tx_rqst, busy}, tx_gain);
    end
    sen_n = 1'b1;
    ptt = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    rx_gain_wr = 1'b1; rx_gain_in = 6'h07;
    @(negedge clk);
    rx_gain_wr = 1'b0;
    w = 0;
    while (!ext_rx_rqst && w < 200) begin @(negedge clk); w++; end
    total++;
    if (cyc < HOLD || rx_gain !== 6'h07) begin
      bad++; $display("FAIL areset_holdoff: got cycle %0d gain %h want >= %0d / 07", cyc, rx_gain, HOLD);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (ext_rx_rqst !== 1'b0) begin bad++; $display("FAIL areset_req: got %b want 0", ext_rx_rqst); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_same_cycle;
    idle_wait(HOLD + 6);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL same_idle_busy: got %b want 0", busy); end
    rx_gain_wr = 1'b1; rx_gain_in = 6'h10;
    @(negedge clk);
    rx_gain_in = 6'h20;
    @(negedge clk);
    rx_gain_wr = 1'b0;
    total++;
    if ({ext_rx_rqst, rx_pending, rx_gain} !== {2'b11, 6'h10}) begin
      bad++; $display("FAIL same_issue: got %b/%h want 11/10", {ext_rx_rqst, rx_pending}, rx_gain);
    end
    start_xfer(1'b0, 6'h10, "same_old");
    end_xfer(1'b0, 6'h10, "same_old");
    start_xfer(1'b0, 6'h20, "same_new");
    end_xfer(1'b0, 6'h20, "same_new");
    total++;
    if (rx_pending !== 1'b0) begin bad++; $display("FAIL same_drain: got %b want 0", rx_pending); end
  endtask

  task automatic test_exclusive;
    total++;
    if (both_hi !== 0) begin bad++; $display("FAIL exclusive: got %0d overlap cycles want 0", both_hi); end
  endtask

  initial begin
    reset_n = 1'b0;
    rx_gain_wr = 1'b0; tx_gain_wr = 1'b0;
    rx_gain_in = 6'd0; tx_gain_in = 6'd0;
    ptt = 1'b0; sen_n = 1'b1;
    test_reset;
    test_holdoff;
    test_priority;
    test_coalesce;
    test_timeout;
    test_async_reset;
    test_same_cycle;
    test_exclusive;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
